// File: rtl/shift_reg_seq_if.sv
// Handshake/data bundle for shift_reg_seq.
// Carries parity only when SHIFT_REG_SEQ_PARITY_EN is defined.
interface shift_reg_seq_if #(
  parameter int WIDTH = 7,
  parameter int AMT_W = 3
);
  logic             load;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;
`ifdef SHIFT_REG_SEQ_PARITY_EN
  logic             parity;
`endif

  modport master (
    output load, d, start, mode, amount, sin,
`ifdef SHIFT_REG_SEQ_PARITY_EN
    input  parity,
`endif
    input  q, sout, busy, done
  );

  modport slave (
    input  load, d, start, mode, amount, sin,
`ifdef SHIFT_REG_SEQ_PARITY_EN
    output parity,
`endif
    output q, sout, busy, done
  );
endinterface

// File: rtl/shift_reg_seq.sv
// Sequenced shift/rotate register, one bit position per clock.
// Optional parity output: define SHIFT_REG_SEQ_PARITY_EN.
module shift_reg_seq #(
  parameter int WIDTH = 7,
  parameter int AMT_W = 3
) (
  input logic         clk,
  input logic         reset,
  shift_reg_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] q_r;
  logic             sout_r;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] q_step;
  logic             sout_step;
  logic             accept;
  logic             last;

  assign accept = (state == IDLE)
                & ~bus.load & bus.start;
  // a zero count still spends one busy cycle
  assign last = (cnt <= AMT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == IDLE):  if (accept) nxt = SHIFT;
      (state == SHIFT): if (last) nxt = DONE;
      default:          nxt = IDLE;
    endcase
  end

  always_comb begin
    q_step    = q_r;
    sout_step = sout_r;
    unique case (mode_r)
      2'b00: begin
        q_step    = {q_r[WIDTH-2:0], bus.sin};
        sout_step = q_r[WIDTH-1];
      end
      2'b01: begin
        q_step    = {bus.sin, q_r[WIDTH-1:1]};
        sout_step = q_r[0];
      end
      2'b10: begin
        q_step    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        sout_step = q_r[WIDTH-1];
      end
      default: begin
        q_step    = {q_r[0], q_r[WIDTH-1:1]};
        sout_step = q_r[0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r    <= '0;
      sout_r <= 1'b0;
      cnt    <= '0;
      mode_r <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            q_r <= bus.d;
          end else if (bus.start) begin
            mode_r <= bus.mode;
            cnt    <= bus.amount;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            q_r    <= q_step;
            sout_r <= sout_step;
            cnt    <= cnt - AMT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state == SHIFT);
    bus.done = (state == DONE);
  end

  assign bus.q    = q_r;
  assign bus.sout = sout_r;

`ifdef SHIFT_REG_SEQ_PARITY_EN
  assign bus.parity = ^q_r;
`endif
endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: directed literals plus random
// stimulus checked every cycle against a behavioural model.
module tb_shift_reg_seq;
  localparam int W = 7;
  localparam int A = 3;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_reg_seq_if #(.WIDTH(W), .AMT_W(A)) bus();

  shift_reg_seq #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  bit en = 0;

  // model: ph 0 idle, 1 running, 2 done
  int mq = 0;
  int ms = 0;
  int mm = 0;
  int left = 0;
  int ph = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic step(int sin);
    case (mm)
      0: begin
        ms = (mq >> (W-1)) & 1;
        mq = ((mq * 2) + sin) & MASK;
      end
      1: begin
        ms = mq & 1;
        mq = (mq / 2) + (sin << (W-1));
      end
      2: begin
        ms = (mq >> (W-1)) & 1;
        mq = ((mq * 2) + ms) & MASK;
      end
      default: begin
        ms = mq & 1;
        mq = (mq / 2) + (ms << (W-1));
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      mq = 0; ms = 0; mm = 0; left = 0; ph = 0;
    end else begin
      case (ph)
        0: begin
          if (bus.load) begin
            mq = int'(bus.d);
          end else if (bus.start) begin
            mm   = int'(bus.mode);
            left = int'(bus.amount);
            ph   = 1;
          end
        end
        1: begin
          if (left > 0) begin
            step(int'(bus.sin));
            left--;
          end
          if (left == 0) ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("q", 32'(bus.q), 32'(mq));
      chk("sout", 32'(bus.sout), 32'(ms));
      chk("busy", 32'(bus.busy), 32'(ph == 1));
      chk("done", 32'(bus.done), 32'(ph == 2));
`ifdef SHIFT_REG_SEQ_PARITY_EN
      chk("parity", 32'(bus.parity),
          32'($countones(mq) % 2));
`endif
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_in();
    bus.load = 0; bus.d = '0; bus.start = 0;
    bus.mode = 2'b00; bus.amount = '0; bus.sin = 0;
  endtask

  task automatic go(logic [1:0] md, int amt, logic s);
    bus.start = 1; bus.mode = md;
    bus.amount = A'(amt); bus.sin = s;
    cyc();
    bus.start = 0;
  endtask

  task automatic ld(logic [W-1:0] v);
    bus.load = 1; bus.d = v;
    cyc();
    bus.load = 0;
  endtask

  initial begin
    idle_in();
    reset = 0;
    cyc(2);
    reset = 1;
    en = 1;
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    ld(7'b0000111);
    chk("ld_q", 32'(bus.q), 32'b0000111);
    chk("ld_sout", 32'(bus.sout), 32'd0);
`ifdef SHIFT_REG_SEQ_PARITY_EN
    chk("ld_par", 32'(bus.parity), 32'd1);
`endif

    go(2'b00, 2, 1'b0);
    chk("shl_busy0", 32'(bus.busy), 32'd1);
    cyc();
    chk("shl_e1", 32'(bus.q), 32'b0001110);
    cyc();
    chk("shl_e2", 32'(bus.q), 32'b0011100);
    chk("shl_done", 32'(bus.done), 32'd1);
    chk("shl_sout", 32'(bus.sout), 32'd0);
    cyc();
    chk("shl_done_end", 32'(bus.done), 32'd0);

    ld(7'b0000111);
    go(2'b11, 3, 1'b0);
    cyc(3);
    chk("ror_q", 32'(bus.q), 32'b1110000);
    chk("ror_sout", 32'(bus.sout), 32'd1);
    chk("ror_done", 32'(bus.done), 32'd1);
    cyc();

    ld(7'b0000000);
    go(2'b01, 7, 1'b1);
    cyc(2);
    bus.start = 1; bus.load = 1; bus.d = 7'b1010101;
    cyc();
    bus.start = 0; bus.load = 0;
    cyc(4);
    chk("shr_q", 32'(bus.q), 32'h7f);
    chk("shr_sout", 32'(bus.sout), 32'd0);
    chk("shr_done", 32'(bus.done), 32'd1);
    cyc();

    go(2'b10, 0, 1'b0);
    chk("z_busy", 32'(bus.busy), 32'd1);
    cyc();
    chk("z_done", 32'(bus.done), 32'd1);
    chk("z_q", 32'(bus.q), 32'h7f);
    cyc();
    chk("z_idle", 32'(bus.done), 32'd0);

    ld(7'b0000111);
    go(2'b10, 5, 1'b0);
    cyc();
    reset = 0;
    cyc();
    reset = 1;
    chk("ab_q", 32'(bus.q), 32'd0);
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_done", 32'(bus.done), 32'd0);
    cyc(3);
    chk("ab_nodone", 32'(bus.done), 32'd0);
    go(2'b00, 1, 1'b1);
    cyc();
    chk("ab_rerun", 32'(bus.q), 32'd1);
    cyc();

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(63) != 0);
      bus.load   = ($urandom_range(7) == 0);
      bus.start  = ($urandom_range(3) == 0);
      bus.d      = W'($urandom);
      bus.mode   = 2'($urandom);
      bus.amount = A'($urandom);
      bus.sin    = 1'($urandom);
      cyc();
    end
    reset = 1;
    idle_in();
    cyc(10);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
